// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES GF(2^8) types and InvMixColumns constant multipliers.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1b;

  typedef logic [7:0] byte_t;
  // Index 0 is the most significant byte of a packed column, i.e. row 0.
  typedef byte_t [0:3] col_t;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic byte_t gmul9(input byte_t b);
    byte_t x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic byte_t gmul11(input byte_t b);
    byte_t x2, x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic byte_t gmul13(input byte_t b);
    byte_t x4, x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic byte_t gmul14(input byte_t b);
    byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// rtl/inv_mix_column_word.sv - combinational InvMixColumns of one 32-bit column.
module inv_mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  col_t a;
  col_t r;

  always_comb begin
    a = col_in;
    r[0] = gmul14(a[0]) ^ gmul11(a[1]) ^ gmul13(a[2]) ^ gmul9(a[3]);
    r[1] = gmul9(a[0])  ^ gmul14(a[1]) ^ gmul11(a[2]) ^ gmul13(a[3]);
    r[2] = gmul13(a[0]) ^ gmul9(a[1])  ^ gmul14(a[2]) ^ gmul11(a[3]);
    r[3] = gmul11(a[0]) ^ gmul13(a[1]) ^ gmul9(a[2])  ^ gmul14(a[3]);
    col_out = r;
  end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// rtl/inv_mix_columns_seq.sv - sequential InvMixColumns, COLS_PER_CYCLE columns per clock.
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

  state_e             state_q, state_d;
  logic [1:0]         col_cnt_q, col_cnt_d;
  // Index 0 is column 0, held in the top 32 bits of the state.
  logic [0:3][31:0]   work_q, work_d;
  logic [31:0]        sel_col [COLS_PER_CYCLE];
  logic [31:0]        mix_col [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    inv_mix_column_word u_word (
      .col_in  (sel_col[g]),
      .col_out (mix_col[g])
    );
  end

  always_comb begin
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      sel_col[g] = work_q[col_cnt_q + 2'(g)];
    end
  end

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    work_d    = work_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    state_out = '0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d    = state_in;
          col_cnt_d = '0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          work_d[col_cnt_q + 2'(g)] = mix_col[g];
        end
        col_cnt_d = col_cnt_q + CNT_STEP;
        if (col_cnt_q == LAST_CNT) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        state_out = work_q;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      col_cnt_q <= '0;
      work_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      work_q    <= work_d;
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb/tb_inv_mix_columns_seq.sv - directed and random checks of inv_mix_columns_seq.
module tb_inv_mix_columns_seq;

  logic         clk;
  logic         rst_n;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [2:0]   out_valid;
  logic [2:0]   out_ready;
  logic [127:0] state_in  [3];
  logic [127:0] state_out [3];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_q[$];
  logic [127:0] out_q[$];

  inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .state_in(state_in[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .state_out(state_out[0])
  );
  inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .state_in(state_in[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .state_out(state_out[1])
  );
  inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .state_in(state_in[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .state_out(state_out[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && in_valid[0] && in_ready[0]) acc_q.push_back(cyc);
    if (rst_n && out_valid[0] && out_ready[0]) out_q.push_back(state_out[0]);
  end

  // Shift-and-add multiply, independent of the xtime chains in the design.
  function automatic logic [7:0] gm(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] col_mul(input logic [127:0] s, input logic [7:0] k0,
      input logic [7:0] k1, input logic [7:0] k2, input logic [7:0] k3);
    logic [127:0] r;
    logic [7:0] a [4];
    logic [7:0] k [4];
    k[0] = k0; k[1] = k1; k[2] = k2; k[3] = k3;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
      for (int i = 0; i < 4; i++) begin
        r[127 - 32*c - 8*i -: 8] = gm(a[0], k[(4 - i) % 4]) ^ gm(a[1], k[(5 - i) % 4])
                                 ^ gm(a[2], k[(6 - i) % 4]) ^ gm(a[3], k[(7 - i) % 4]);
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_model(input logic [127:0] s);
    return col_mul(s, 8'h0e, 8'h0b, 8'h0d, 8'h09);
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s);
    return col_mul(s, 8'h02, 8'h03, 8'h01, 8'h01);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with the instance idle.
  task automatic xfer(input int k, input logic [127:0] s, input logic [127:0] exp,
      input int lat, input string tag);
    int n;
    in_valid[k] = 1'b1;
    state_in[k] = s;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    state_in[k] = ~s;
    n = 0;
    while (out_valid[k] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (lat > 0) check({tag, "_latency"}, 128'(n), 128'(lat));
    check({tag, "_out_valid"}, 128'(out_valid[k]), 128'd1);
    check({tag, "_data"}, state_out[k], exp);
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    check({tag, "_in_ready_after"}, 128'(in_ready[k]), 128'd1);
  endtask

  localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;
  localparam logic [127:0] V2_OUT = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;

  initial begin
    logic [127:0] x;
    int n, acc0;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    for (int k = 0; k < 3; k++) state_in[k] = '0;
    #12;
    for (int k = 0; k < 3; k++) begin
      check("reset_in_ready", 128'(in_ready[k]), 128'd1);
      check("reset_out_valid", 128'(out_valid[k]), 128'd0);
      check("reset_state_out", state_out[k], 128'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(0, V1_IN, V1_OUT, 4, "single_c1");
    xfer(0, V2_IN, V2_OUT, 4, "known_c1");
    xfer(0, 128'h0, 128'h0, 4, "zero_c1");
    xfer(1, V1_IN, V1_OUT, 2, "single_c2");
    xfer(1, V2_IN, V2_OUT, 2, "known_c2");
    xfer(1, 128'h0, 128'h0, 2, "zero_c2");
    xfer(2, V1_IN, V1_OUT, 1, "single_c4");
    xfer(2, V2_IN, V2_OUT, 1, "known_c4");
    xfer(2, 128'h0, 128'h0, 1, "zero_c4");

    in_valid[0] = 1'b1;
    state_in[0] = V2_IN;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    n = 0;
    while (out_valid[0] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid[0] = 1'b1;
    state_in[0] = V1_IN;
    acc0 = acc_q.size();
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_state_out", state_out[0], V2_OUT);
      check("bp_out_valid", 128'(out_valid[0]), 128'd1);
      check("bp_in_ready", 128'(in_ready[0]), 128'd0);
    end
    in_valid[0] = 1'b0;
    check("bp_no_accept", 128'(acc_q.size()), 128'(acc0));
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    check("bp_handshake_data", out_q[out_q.size() - 1], V2_OUT);
    check("bp_in_ready_after", 128'(in_ready[0]), 128'd1);
    check("bp_out_valid_after", 128'(out_valid[0]), 128'd0);

    acc_q.delete();
    out_q.delete();
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    state_in[0]  = V1_IN;
    n = 0;
    while (acc_q.size() < 1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    state_in[0] = V2_IN;
    while (acc_q.size() < 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid[0] = 1'b0;
    while (out_q.size() < 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready[0] = 1'b0;
    check("b2b_out_count", 128'(out_q.size()), 128'd2);
    check("b2b_accept_count", 128'(acc_q.size()), 128'd2);
    if (out_q.size() >= 2 && acc_q.size() >= 2) begin
      check("b2b_first", out_q[0], V1_OUT);
      check("b2b_second", out_q[1], V2_OUT);
      check("b2b_idle_cycles_between_accepts", 128'(acc_q[1] - acc_q[0] - 1), 128'd5);
    end

    in_valid[0] = 1'b1;
    state_in[0] = V1_IN;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", 128'(in_ready[0]), 128'd1);
    check("rst_out_valid", 128'(out_valid[0]), 128'd0);
    check("rst_state_out", state_out[0], 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_idle_no_output", 128'(out_valid[0]), 128'd0);
    xfer(0, V2_IN, V2_OUT, 4, "after_rst");

    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      xfer(0, x, inv_model(x), 4, "random_c1");
    end
    for (int i = 0; i < 50; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      xfer(2, mix_model(x), x, 1, "roundtrip_c4");
    end
    for (int i = 0; i < 50; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      xfer(1, mix_model(x), x, 2, "roundtrip_c2");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
